// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transmit packet sequencer:
// line commands, PID codes, FSM states and CRC parameters.
package usb_pkg;

    typedef enum logic [1:0] {
        LC_IDLE = 2'd0,
        LC_DATA = 2'd1,
        LC_SE0  = 2'd2,
        LC_J    = 2'd3
    } line_cmd_t;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_t;

    typedef enum logic [1:0] {
        PK_TOKEN,
        PK_DATA,
        PK_HSHAKE,
        PK_BAD
    } pkt_kind_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_TOKEN,
        ST_DATA,
        ST_CRC,
        ST_FLUSH,
        ST_EOP_SE0,
        ST_EOP_J
    } state_t;

    localparam logic [4:0]  CRC5_POLY    = 5'h05;
    localparam logic [4:0]  CRC5_INIT    = 5'h1F;
    localparam logic [15:0] CRC16_POLY   = 16'h8005;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
    // Sent LSB first: seven zeros then a one.
    localparam logic [7:0]  SYNC_PATTERN = 8'b1000_0000;

    function automatic pkt_kind_t classify_pid(input logic [3:0] pid);
        pkt_kind_t kind;
        kind = PK_BAD;
        case (pid)
            PID_OUT, PID_IN, PID_SETUP:   kind = PK_TOKEN;
            PID_DATA0, PID_DATA1:         kind = PK_DATA;
            PID_ACK, PID_NAK, PID_STALL:  kind = PK_HSHAKE;
            default:                      kind = PK_BAD;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/usb_tx_packet_sequencer_if.sv
// Request and bit-stream signals between a packet source, the sequencer
// and the downstream bit-stuffer/NRZI encoder.
interface usb_tx_packet_sequencer_if
    import usb_pkg::*;
#(
    parameter int MAX_BYTES = 8
);
    logic                   req_valid;
    logic                   req_ready;
    logic [3:0]             req_pid;
    logic [6:0]             req_addr;
    logic [3:0]             req_endp;
    logic [3:0]             req_len;
    logic [8*MAX_BYTES-1:0] req_data;
    logic                   bit_out;
    logic                   bit_valid;
    logic                   bit_ready;
    line_cmd_t              line_cmd;
    logic                   done;
    logic                   pid_err;

    modport master (
        output req_valid, req_pid, req_addr, req_endp, req_len, req_data, bit_ready,
        input  req_ready, bit_out, bit_valid, line_cmd, done, pid_err
    );

    modport slave (
        input  req_valid, req_pid, req_addr, req_endp, req_len, req_data, bit_ready,
        output req_ready, bit_out, bit_valid, line_cmd, done, pid_err
    );
endinterface

// File: rtl/usb_crc_unit.sv
// Serial USB CRC5/CRC16 generator fed one raw bit at a time in send order;
// presents the complemented remainder and the field bit selected by index.
module usb_crc_unit
    import usb_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        enable,
    input  logic        sel,
    input  logic        din,
    input  logic [3:0]  idx,
    output logic [15:0] field,
    output logic        field_bit
);
    logic [4:0]  crc5;
    logic [15:0] crc16;

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic d);
        logic fb;
        fb = d ^ c[4];
        return {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
        logic fb;
        fb = d ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

    always_ff @(posedge clock) begin
        if (clear) begin
            crc5  <= CRC5_INIT;
            crc16 <= CRC16_INIT;
        end else if (enable) begin
            if (sel)
                crc16 <= crc16_step(crc16, din);
            else
                crc5 <= crc5_step(crc5, din);
        end
    end

    // Field goes out MSB first, so index 0 selects the top bit.
    assign field     = sel ? ~crc16 : {11'd0, ~crc5};
    assign field_bit = sel ? field[4'd15 - idx] : field[4'd4 - idx];

endmodule

// File: rtl/usb_tx_packet_sequencer.sv
// USB host transmit packet sequencer: walks SYNC, PID, body, CRC and EOP,
// emitting a raw LSB-first bit stream and line-state commands.
module usb_tx_packet_sequencer
    import usb_pkg::*;
#(
    parameter int MAX_BYTES = 8
)(
    input logic                      clock,
    input logic                      reset,
    usb_tx_packet_sequencer_if.slave bus
);
    localparam int DATA_BITS = 8 * MAX_BYTES;
    localparam int CNT_W     = (DATA_BITS > 16) ? $clog2(DATA_BITS) : 4;

    state_t               state, state_nxt, field_after;
    logic [CNT_W-1:0]     idx, idx_nxt, last_idx, data_last;
    pkt_kind_t            req_kind, kind_q;
    logic [3:0]           pid_q, len_q, len_sat;
    logic [10:0]          tok_sr;
    logic [DATA_BITS-1:0] data_sr;
    logic [7:0]           pid_byte;
    logic                 accept, bad_pid, done_q, pid_err_q;
    logic                 bit_valid_c, bit_out_c, crc_en, crc_bit;
    line_cmd_t            line_cmd_c;
    logic [15:0]          crc_field_unused;

    assign req_kind  = classify_pid(bus.req_pid);
    assign accept    = (state == ST_IDLE) && bus.req_valid && (req_kind != PK_BAD);
    assign bad_pid   = (state == ST_IDLE) && bus.req_valid && (req_kind == PK_BAD);
    assign len_sat   = (int'(bus.req_len) > MAX_BYTES) ? 4'(MAX_BYTES) : bus.req_len;
    assign pid_byte  = {~pid_q, pid_q};
    assign data_last = CNT_W'({len_q, 3'b000} - 7'd1);
    assign crc_en    = bit_valid_c && bus.bit_ready && ((state == ST_TOKEN) || (state == ST_DATA));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            done_q    <= 1'b0;
            pid_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            done_q    <= (state == ST_EOP_J);
            pid_err_q <= bad_pid;
        end
    end

    // Request fields are captured on accept; body fields then shift out LSB first.
    always_ff @(posedge clock) begin
        if (accept) begin
            kind_q  <= req_kind;
            pid_q   <= bus.req_pid;
            len_q   <= len_sat;
            tok_sr  <= {bus.req_endp, bus.req_addr};
            data_sr <= bus.req_data;
        end else if (bit_valid_c && bus.bit_ready) begin
            if (state == ST_TOKEN) tok_sr  <= tok_sr >> 1;
            if (state == ST_DATA)  data_sr <= data_sr >> 1;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        bit_valid_c = 1'b0;
        bit_out_c   = 1'b0;
        line_cmd_c  = LC_IDLE;
        last_idx    = '0;
        field_after = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SYNC;
                    idx_nxt   = '0;
                end
            end
            ST_SYNC: begin
                bit_out_c   = SYNC_PATTERN[idx[2:0]];
                last_idx    = CNT_W'(7);
                field_after = ST_PID;
            end
            ST_PID: begin
                bit_out_c = pid_byte[idx[2:0]];
                last_idx  = CNT_W'(7);
                case (kind_q)
                    PK_TOKEN: field_after = ST_TOKEN;
                    PK_DATA:  field_after = (len_q == 4'd0) ? ST_CRC : ST_DATA;
                    default:  field_after = ST_FLUSH;
                endcase
            end
            ST_TOKEN: begin
                bit_out_c   = tok_sr[0];
                last_idx    = CNT_W'(10);
                field_after = ST_CRC;
            end
            ST_DATA: begin
                bit_out_c   = data_sr[0];
                last_idx    = data_last;
                field_after = ST_CRC;
            end
            ST_CRC: begin
                bit_out_c   = crc_bit;
                last_idx    = (kind_q == PK_TOKEN) ? CNT_W'(4) : CNT_W'(15);
                field_after = ST_FLUSH;
            end
            ST_FLUSH: begin
                line_cmd_c = LC_DATA;
                idx_nxt    = '0;
                if (bus.bit_ready) state_nxt = ST_EOP_SE0;
            end
            ST_EOP_SE0: begin
                line_cmd_c = LC_SE0;
                if (idx == CNT_W'(1)) begin
                    state_nxt = ST_EOP_J;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + CNT_W'(1);
                end
            end
            ST_EOP_J: begin
                line_cmd_c = LC_J;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // All bit-carrying fields share one advance rule gated by the encoder.
        if ((state == ST_SYNC) || (state == ST_PID) || (state == ST_TOKEN) ||
            (state == ST_DATA) || (state == ST_CRC)) begin
            line_cmd_c  = LC_DATA;
            bit_valid_c = 1'b1;
            if (bus.bit_ready) begin
                if (idx == last_idx) begin
                    state_nxt = field_after;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + CNT_W'(1);
                end
            end
        end
    end

    usb_crc_unit crc_unit (
        .clock     (clock),
        .clear     (accept),
        .enable    (crc_en),
        .sel       (kind_q == PK_DATA),
        .din       (bit_out_c),
        .idx       (idx[3:0]),
        .field     (crc_field_unused),
        .field_bit (crc_bit)
    );

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.bit_valid = bit_valid_c;
    assign bus.bit_out   = bit_out_c;
    assign bus.line_cmd  = line_cmd_c;
    assign bus.done      = done_q;
    assign bus.pid_err   = pid_err_q;

endmodule

// File: tb/tb_usb_tx_packet_sequencer.sv
// Directed bench for the USB transmit packet sequencer with hand-computed
// bit streams and CRC fields.
module tb_usb_tx_packet_sequencer;
    import usb_pkg::*;

    localparam int MAX_BYTES = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad   = 0;

    int           cap_n, cap_se0, cap_j, cap_done, cap_flush, cap_hold_err;
    logic [127:0] cap_bits;
    logic         done_ready, first_valid, first_ready;
    line_cmd_t    done_line;

    always #5 clock = ~clock;

    usb_tx_packet_sequencer_if #(.MAX_BYTES(MAX_BYTES)) bus ();

    usb_tx_packet_sequencer #(.MAX_BYTES(MAX_BYTES)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Raw bit stream in send order: bit n of the result is the n-th bit on the wire.
    function automatic logic [127:0] expect_bits(input logic [3:0] pid, input logic [6:0] addr,
                                                 input logic [3:0] endp, input int nbody,
                                                 input logic [63:0] data, input logic [15:0] crc,
                                                 input int crc_w, input bit token);
        logic [127:0] v;
        logic [7:0]   pb;
        int           n;
        v  = '0;
        n  = 0;
        pb = {~pid, pid};
        for (int i = 0; i < 8; i++) begin v[n] = (i == 7); n++; end
        for (int i = 0; i < 8; i++) begin v[n] = pb[i]; n++; end
        if (token) begin
            for (int i = 0; i < 7; i++) begin v[n] = addr[i]; n++; end
            for (int i = 0; i < 4; i++) begin v[n] = endp[i]; n++; end
        end
        for (int i = 0; i < nbody; i++) begin v[n] = data[i]; n++; end
        for (int i = crc_w - 1; i >= 0; i--) begin v[n] = crc[i]; n++; end
        return v;
    endfunction

    task automatic issue(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                         input logic [3:0] len, input logic [63:0] data, input bit hold);
        @(negedge clock);
        bus.req_pid   = pid;
        bus.req_addr  = addr;
        bus.req_endp  = endp;
        bus.req_len   = len;
        bus.req_data  = data;
        bus.req_valid = 1'b1;
        bus.bit_ready = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic run_packet(input int stall_every, input bit drop_valid);
        bit   stalled;
        logic held;
        cap_n = 0; cap_se0 = 0; cap_j = 0; cap_done = 0; cap_flush = 0; cap_hold_err = 0;
        cap_bits = '0; done_ready = 1'b0; done_line = LC_DATA;
        stalled = 1'b0; held = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if (c == 0) begin
                first_valid = bus.bit_valid;
                first_ready = bus.req_ready;
                if (drop_valid) bus.req_valid = 1'b0;
            end
            bus.bit_ready = (stall_every == 0) || ((c % stall_every) != stall_every - 1);
            if (stalled && (bus.bit_out !== held)) cap_hold_err++;
            stalled = bus.bit_valid && !bus.bit_ready;
            held    = bus.bit_out;
            if (bus.bit_valid && bus.bit_ready) begin
                if (cap_n < 128) cap_bits[cap_n] = bus.bit_out;
                cap_n++;
            end
            if (bus.line_cmd == LC_SE0) cap_se0++;
            if (bus.line_cmd == LC_J) cap_j++;
            if ((bus.line_cmd == LC_DATA) && !bus.bit_valid) cap_flush++;
            if (bus.done) begin
                cap_done++;
                done_ready = bus.req_ready;
                done_line  = bus.line_cmd;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        bus.req_valid = 1'b0;
        bus.req_pid   = 4'd0;
        bus.req_addr  = 7'd0;
        bus.req_endp  = 4'd0;
        bus.req_len   = 4'd0;
        bus.req_data  = 64'd0;
        bus.bit_ready = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_bit_valid", bus.bit_valid, 0);
        check("rst_bit_out",   bus.bit_out, 0);
        check("rst_line_cmd",  bus.line_cmd, LC_IDLE);
        check("rst_done",      bus.done, 0);
        check("rst_pid_err",   bus.pid_err, 0);
        reset = 1'b0;

        // OUT token
        issue(4'b0001, 7'h3A, 4'hA, 4'd0, 64'd0, 1'b0);
        run_packet(0, 1'b1);
        check("out_count", cap_n, 32);
        check("out_bits", cap_bits, expect_bits(4'b0001, 7'h3A, 4'hA, 0, 64'd0, 16'h001C, 5, 1'b1));
        check("out_flush", cap_flush, 1);
        check("out_se0", cap_se0, 2);
        check("out_j", cap_j, 1);
        check("out_done", cap_done, 1);
        check("out_done_ready", done_ready, 1);
        check("out_done_line", done_line, LC_IDLE);

        // SETUP token
        issue(4'b1101, 7'h15, 4'hE, 4'd0, 64'd0, 1'b0);
        run_packet(0, 1'b1);
        check("setup_count", cap_n, 32);
        check("setup_bits", cap_bits, expect_bits(4'b1101, 7'h15, 4'hE, 0, 64'd0, 16'h0017, 5, 1'b1));
        check("setup_done", cap_done, 1);

        // DATA0, four bytes
        issue(4'b0011, 7'h00, 4'h0, 4'd4, 64'h0000_0000_0302_0100, 1'b0);
        run_packet(0, 1'b1);
        check("data0_count", cap_n, 64);
        check("data0_bits", cap_bits,
              expect_bits(4'b0011, 7'h00, 4'h0, 32, 64'h0000_0000_0302_0100, 16'hF75E, 16, 1'b0));
        check("data0_done", cap_done, 1);

        // DATA1, zero length, encoder stalling every third cycle
        issue(4'b1011, 7'h00, 4'h0, 4'd0, 64'd0, 1'b0);
        run_packet(3, 1'b1);
        check("data1_count", cap_n, 32);
        check("data1_bits", cap_bits, expect_bits(4'b1011, 7'h00, 4'h0, 0, 64'd0, 16'h0000, 16, 1'b0));
        check("data1_hold", cap_hold_err, 0);
        check("data1_se0", cap_se0, 2);
        check("data1_done", cap_done, 1);

        // ACK with req_valid held, then NAK accepted on the done cycle
        issue(4'b0010, 7'h00, 4'h0, 4'd0, 64'd0, 1'b1);
        run_packet(0, 1'b0);
        check("ack_count", cap_n, 16);
        check("ack_bits", cap_bits, expect_bits(4'b0010, 7'h00, 4'h0, 0, 64'd0, 16'h0000, 0, 1'b0));
        check("ack_done_ready", done_ready, 1);
        bus.req_pid = 4'b1010;
        run_packet(0, 1'b1);
        check("b2b_first_valid", first_valid, 1);
        check("b2b_first_ready", first_ready, 0);
        check("nak_count", cap_n, 16);
        check("nak_bits", cap_bits, expect_bits(4'b1010, 7'h00, 4'h0, 0, 64'd0, 16'h0000, 0, 1'b0));
        check("nak_done", cap_done, 1);

        // Oversized length clamps to MAX_BYTES
        issue(4'b0011, 7'h00, 4'h0, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_packet(0, 1'b1);
        check("sat_count", cap_n, 96);
        check("sat_done", cap_done, 1);

        // Unsupported PID
        @(negedge clock);
        bus.req_pid   = 4'b0000;
        bus.req_valid = 1'b1;
        @(negedge clock);
        check("badpid_err", bus.pid_err, 1);
        check("badpid_ready", bus.req_ready, 1);
        check("badpid_bit_valid", bus.bit_valid, 0);
        bus.req_valid = 1'b0;
        @(negedge clock);
        check("badpid_err_clear", bus.pid_err, 0);
        check("badpid_line", bus.line_cmd, LC_IDLE);

        // Reset in the middle of a DATA payload
        issue(4'b0011, 7'h00, 4'h0, 4'd8, 64'h0123_4567_89AB_CDEF, 1'b0);
        repeat (20) @(negedge clock);
        check("midrst_pre_line", bus.line_cmd, LC_DATA);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_line", bus.line_cmd, LC_IDLE);
        check("midrst_bit_valid", bus.bit_valid, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_ready", bus.req_ready, 1);
        reset  = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done || bus.bit_valid) n_done++;
        end
        check("midrst_quiet", n_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
